// File: rtl/loop_index_ctrl.sv
// Index stream generator: on start, emits 0..limit-1 over valid/ready with stall, abort and done.
// Optional build macro LOOP_INDEX_SKIP_EN omits index SKIP_IDX from the stream.
module loop_index_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned SKIP_IDX = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] limit,
  input  logic             enable,
  input  logic             abort,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [CNT_W-1:0] idx,
  output logic             idx_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int unsigned EXT_W = CNT_W + 1;
`ifdef LOOP_INDEX_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  localparam logic [EXT_W-1:0] FIRST_IDX = (SKIP_EN && (SKIP_IDX == 0)) ? EXT_W'(1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] idx_d, beat_d;
  logic             valid_d, last_d, busy_d, done_d;
  logic [EXT_W-1:0] idx_nxt;

  // Extra bit keeps the successor of 2^CNT_W-1 from wrapping back under limit.
  function automatic logic [EXT_W-1:0] next_index(input logic [EXT_W-1:0] cur);
    logic [EXT_W-1:0] n;
    n = cur + EXT_W'(1);
    if (SKIP_EN && (n == EXT_W'(SKIP_IDX))) n = n + EXT_W'(1);
    return n;
  endfunction

  assign idx_nxt = next_index({1'b0, idx});

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    idx_d   = idx;
    last_d  = idx_last;
    valid_d = idx_valid;
    beat_d  = beat_cnt;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lim_d   = limit;
          beat_d  = '0;
          idx_d   = CNT_W'(FIRST_IDX);
          last_d  = next_index(FIRST_IDX) >= {1'b0, limit};
          state_d = (FIRST_IDX >= {1'b0, limit}) ? S_FINISH : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // Abort wins over a same-cycle handshake; that beat is dropped.
        if (abort) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (idx_valid && idx_ready) begin
          beat_d = beat_cnt + CNT_W'(1);
          if (idx_last) begin
            valid_d = 1'b0;
            state_d = S_FINISH;
          end else begin
            idx_d   = CNT_W'(idx_nxt);
            last_d  = next_index(idx_nxt) >= {1'b0, lim_q};
            valid_d = enable;
          end
        end else if (!idx_valid && enable) begin
          valid_d = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lim_q     <= '0;
      idx       <= '0;
      idx_last  <= 1'b0;
      idx_valid <= 1'b0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lim_q     <= lim_d;
      idx       <= idx_d;
      idx_last  <= last_d;
      idx_valid <= valid_d;
      beat_cnt  <= beat_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_loop_index_ctrl.sv
// Bench for loop_index_ctrl: table-driven runs, corner sequences and randomized runs vs a queue model.
module tb_loop_index_ctrl;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SKIP_IDX = 5;
`ifdef LOOP_INDEX_SKIP_EN
  localparam bit SKIP_ON = 1'b1;
`else
  localparam bit SKIP_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, enable, abort, idx_ready;
  logic [CNT_W-1:0] limit;
  logic             idx_valid, idx_last, busy, done;
  logic [CNT_W-1:0] idx, beat_cnt;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  loop_index_ctrl #(.CNT_W(CNT_W), .SKIP_IDX(SKIP_IDX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .limit(limit), .enable(enable),
    .abort(abort), .idx_valid(idx_valid), .idx_ready(idx_ready), .idx(idx),
    .idx_last(idx_last), .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the list of indices a run with this limit must emit, in order.
  function automatic void build_exp(input int lim);
    exp_q.delete();
    for (int i = 0; i < lim; i++)
      if (!(SKIP_ON && i == int'(SKIP_IDX))) exp_q.push_back(i);
  endfunction

  // mode 0: full rate; 1: random enable/ready; 2: ready held low 5 cycles on idx 1 with enable toggling.
  task automatic run(input int lim, input int mode, input int abort_at, input bit poke,
                     output int got_cnt, output int got_last);
    int pos = 0, cyc = 1, stall = 0, first_cyc = -1;
    bit act, pact = 0, fin = 0, aborted = 0, phs = 0, hs_last = 0, pv = 0, pen = 0;
    bit exp_v, exp_d;
    logic [CNT_W-1:0] pidx = '0;
    build_exp(lim);
    got_last = -1;
    @(negedge clk);
    start = 1'b1; limit = CNT_W'(lim); enable = 1'b1; idx_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    act = (exp_q.size() > 0);
    while (!fin) begin
      if (cyc == 1) begin
        exp_v = 1'b0;
        exp_d = (exp_q.size() == 0);
      end else begin
        exp_d = phs && hs_last;
        if (!pact || aborted)  exp_v = 1'b0;
        else if (pv && !phs)   exp_v = 1'b1;
        else if (phs)          exp_v = hs_last ? 1'b0 : pen;
        else                   exp_v = pen;
      end
      chk("idx_valid", int'(idx_valid), int'(exp_v));
      chk("done", int'(done), int'(exp_d));
      chk("busy", int'(busy), int'(act || exp_d));
      chk("beat_cnt", int'(beat_cnt), pos);
      if (idx_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (pos < exp_q.size()) begin
          chk("idx", int'(idx), exp_q[pos]);
          chk("idx_last", int'(idx_last), int'(pos == exp_q.size() - 1));
        end else begin
          chk("extra_beat", pos, exp_q.size() - 1);
        end
        if (pv && !phs && !aborted) chk("idx_hold", int'(idx), int'(pidx));
        if (idx_last) got_last = int'(idx);
      end
      fin = exp_d || aborted;
      if (cyc > 4000) begin
        chk("run_timeout", cyc, 4000);
        fin = 1'b1;
      end
      if (!fin) begin
        pact = act; phs = 1'b0; hs_last = 1'b0; abort = 1'b0;
        enable = 1'b1; idx_ready = 1'b1;
        if (mode == 1) begin
          enable    = 1'($urandom_range(0, 1));
          idx_ready = 1'($urandom_range(0, 1));
        end else if (mode == 2 && idx_valid && idx == CNT_W'(1) && stall < 5) begin
          idx_ready = 1'b0;
          enable    = stall[0];
          stall++;
        end
        if (poke && cyc == 4) begin start = 1'b1; limit = CNT_W'(2); end
        else start = 1'b0;
        if (idx_valid && idx_ready) begin
          if (int'(idx) == abort_at) begin
            abort = 1'b1; aborted = 1'b1; act = 1'b0;
          end else begin
            phs = 1'b1; pos++;
            hs_last = (pos == exp_q.size());
            if (hs_last) act = 1'b0;
          end
        end
        pen = enable; pv = idx_valid; pidx = idx;
        @(negedge clk);
        cyc++;
      end
    end
    if (mode == 0 && exp_q.size() > 0 && !poke) chk("first_latency", first_cyc, 2);
    if (mode == 2) chk("stall_cycles", stall, 5);
    got_cnt = int'(beat_cnt);
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_busy", int'(busy), 0);
    chk("post_done", int'(done), 0);
    chk("post_valid", int'(idx_valid), 0);
  endtask

  typedef struct {
    int lim;
    int mode;
    int exp_cnt;
    int exp_last;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int cnt, last, n, lim, ab, exp_cnt;
    tbl[0] = '{4,   0, 4, 3};
    tbl[1] = '{3,   2, 3, 2};
    tbl[2] = '{0,   0, 0, -1};
    tbl[3] = '{1,   0, 1, 0};
    tbl[4] = '{8,   0, SKIP_ON ? 7 : 8, 7};
    tbl[5] = '{6,   0, SKIP_ON ? 5 : 6, SKIP_ON ? 4 : 5};
    tbl[6] = '{255, 0, SKIP_ON ? 254 : 255, 254};

    rst_n = 1'b0; start = 1'b0; limit = '0; enable = 1'b0; abort = 1'b0; idx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(idx_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_beat_cnt", int'(beat_cnt), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run(tbl[i].lim, tbl[i].mode, -1, 1'b0, cnt, last);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_last", i), last, tbl[i].exp_last);
    end

    // Abort on the idx=3 handshake; a start mid-run must be ignored.
    run(10, 0, 3, 1'b1, cnt, last);
    chk("abort_cnt", cnt, 3);
    chk("abort_last", last, -1);

    // Async reset mid-run, checked before any clock edge.
    @(negedge clk);
    start = 1'b1; limit = CNT_W'(10); enable = 1'b1; idx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(idx_valid && idx == CNT_W'(2)) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx2", int'(idx), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(idx_valid), 0);
    chk("mid_rst_idx", int'(idx), 0);
    chk("mid_rst_last", int'(idx_last), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_beat_cnt", int'(beat_cnt), 0);
    #1 rst_n = 1'b1;
    run(2, 0, -1, 1'b0, cnt, last);
    chk("after_rst_cnt", cnt, 2);
    chk("after_rst_last", last, 1);

    for (int r = 0; r < 16; r++) begin
      lim = int'($urandom_range(0, 40));
      ab  = (lim > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, lim - 1)) : -1;
      run(lim, 1, ab, 1'b0, cnt, last);
      exp_cnt = exp_q.size();
      foreach (exp_q[k]) if (exp_q[k] == ab) exp_cnt = k;
      chk($sformatf("rand%0d_cnt", r), cnt, exp_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
